// File: rtl/imem_program_loader.sv
// Instruction-memory program loader.
// Receives a framed byte stream (MAGIC, LEN lo/hi, 4*N payload bytes, XOR checksum)
// over valid/ready. Payload bytes are packed little-endian into 32-bit words, and each
// word is written to instruction memory with a one-cycle strobe. The CPU is held in reset
// until a complete image with a good checksum has been written.
module imem_program_loader #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [7:0]  MAGIC      = 8'hA5
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   word_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_MAGIC, S_LEN0, S_LEN1, S_DATA, S_CHECK, S_DONE, S_ERROR
  } state_t;

  // Largest legal word count; one more than the highest word address.
  localparam logic [16:0] CAP = 17'(1) << ADDR_WIDTH;

  state_t                state_q, state_d;
  logic [7:0]            len_lo_q, len_lo_d;
  logic [15:0]           len_q, len_d;
  logic [23:0]           pack_q, pack_d;
  logic [1:0]            bcnt_q, bcnt_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [7:0]            chk_q, chk_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [ADDR_WIDTH:0]   wcnt_q, wcnt_d;
  logic                  rdy_q, rdy_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  cpurst_q, cpurst_d;

  logic                  accept;
  logic [15:0]           len_new;
  logic                  last_word;

  assign accept    = rx_valid && rdy_q;
  assign len_new   = {rx_data, len_lo_q};
  assign last_word = (16'(idx_q) == (len_q - 16'd1));

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d  = state_q;
    len_lo_d = len_lo_q;
    len_d    = len_q;
    pack_d   = pack_q;
    bcnt_d   = bcnt_q;
    idx_d    = idx_q;
    chk_d    = chk_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wcnt_d   = wcnt_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_MAGIC;
          wcnt_d  = '0;
          chk_d   = '0;
          idx_d   = '0;
          bcnt_d  = '0;
        end
      end
      S_MAGIC: begin
        if (accept) state_d = (rx_data == MAGIC) ? S_LEN0 : S_ERROR;
      end
      S_LEN0: begin
        if (accept) begin
          len_lo_d = rx_data;
          state_d  = S_LEN1;
        end
      end
      S_LEN1: begin
        if (accept) begin
          len_d = len_new;
          if (17'(len_new) > CAP)  state_d = S_ERROR;
          else if (len_new == '0)  state_d = S_CHECK;
          else                     state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          chk_d  = chk_q ^ rx_data;
          bcnt_d = bcnt_q + 2'd1;
          case (bcnt_q)
            2'd0: pack_d[7:0]   = rx_data;
            2'd1: pack_d[15:8]  = rx_data;
            2'd2: pack_d[23:16] = rx_data;
            default: begin
              // Word complete: it is latched into the write registers, so the
              // stream keeps flowing while the strobe is out.
              we_d    = 1'b1;
              addr_d  = idx_q;
              wdata_d = {rx_data, pack_q};
              wcnt_d  = wcnt_q + (ADDR_WIDTH+1)'(1);
              idx_d   = idx_q + ADDR_WIDTH'(1);
              if (last_word) state_d = S_CHECK;
            end
          endcase
        end
      end
      S_CHECK: begin
        if (accept) state_d = (rx_data == chk_q) ? S_DONE : S_ERROR;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d   = (state_d == S_MAGIC) || (state_d == S_LEN0) || (state_d == S_LEN1) ||
               (state_d == S_DATA)  || (state_d == S_CHECK);
    rdy_d    = busy_d;
    done_d   = (state_d == S_DONE);
    err_d    = (state_d == S_ERROR);
    cpurst_d = (state_d != S_DONE);
  end

  // Control state and registered outputs, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      bcnt_q   <= '0;
      idx_q    <= '0;
      chk_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wcnt_q   <= '0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      cpurst_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      bcnt_q   <= bcnt_d;
      idx_q    <= idx_d;
      chk_q    <= chk_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wcnt_q   <= wcnt_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      cpurst_q <= cpurst_d;
    end
  end

  // Length and partial-word holding registers; only read after being written in a load.
  always_ff @(posedge clk) begin
    len_lo_q <= len_lo_d;
    len_q    <= len_d;
    pack_q   <= pack_d;
  end

  assign rx_ready   = rdy_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_reset  = cpurst_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = err_q;
  assign word_count = wcnt_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench for imem_program_loader with an 8-word memory (ADDR_WIDTH=3).
module tb_imem_program_loader;

  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          Reset;
  logic          start;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_reset;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW:0]   word_count;

  imem_program_loader #(.ADDR_WIDTH(AW), .MAGIC(8'hA5)) dut (
    .clk(clk), .Reset(Reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  // Instruction-memory model: records every write strobe.
  logic [31:0]   wr_mem [0:(1<<AW)-1];
  int            wr_cnt = 0;
  logic [AW-1:0] last_addr = '0;
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_mem[imem_addr] = imem_wdata;
      last_addr         = imem_addr;
      wr_cnt            = wr_cnt + 1;
    end
  end

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [7:0]  frame [$];
  logic [31:0] pw [0:15];
  int          base;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int g;
    rx_valid = 1'b0;
    repeat (gap) tick();
    rx_data  = b;
    rx_valid = 1'b1;
    g = 0;
    while (rx_ready !== 1'b1 && g < 20) begin
      tick();
      g++;
    end
    if (g >= 20) chk("ready_timeout", {31'd0, rx_ready}, 32'd1);
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_range(input int from, input int to, input int maxgap);
    for (int i = from; i < to; i++) send_byte(frame[i], $urandom_range(0, maxgap));
  endtask

  // Frame from pw[0..n-1]; lenfield is sent as the length, chk_flip corrupts the checksum.
  task automatic build_frame(input int n, input logic [15:0] lenfield, input logic [7:0] chk_flip);
    logic [7:0] x;
    x = 8'h00;
    frame.delete();
    frame.push_back(8'hA5);
    frame.push_back(lenfield[7:0]);
    frame.push_back(lenfield[15:8]);
    for (int w = 0; w < n; w++) begin
      for (int k = 0; k < 4; k++) begin
        frame.push_back(pw[w][8*k +: 8]);
        x = x ^ pw[w][8*k +: 8];
      end
    end
    frame.push_back(x ^ chk_flip);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    Reset = 1'b1; start = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
    tick(); tick();
    Reset = 1'b0;
    tick();

    // Reset state
    chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("rst_rx_ready",  {31'd0, rx_ready},  32'd0);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    chk("rst_done",      {31'd0, done},      32'd0);
    chk("rst_error",     {31'd0, error},     32'd0);
    chk("rst_wcount",    32'(word_count),    32'd0);
    chk("rst_we",        {31'd0, imem_we},   32'd0);
    chk("rst_addr",      32'(imem_addr),     32'd0);
    chk("rst_wdata",     imem_wdata,         32'd0);

    // Byte offered while idle is not consumed
    rx_data = 8'hA5; rx_valid = 1'b1; tick(); tick(); rx_valid = 1'b0;
    chk("idle_no_ready", {31'd0, rx_ready}, 32'd0);

    // Test 1: two-word program; checksum 13^93^10 = 90
    base = wr_cnt;
    pulse_start();
    chk("t1_busy",  {31'd0, busy},     32'd1);
    chk("t1_ready", {31'd0, rx_ready}, 32'd1);
    frame = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
              8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
    send_range(0, frame.size(), 0);
    chk("t1_done",   {31'd0, done},      32'd1);
    chk("t1_cpurst", {31'd0, cpu_reset}, 32'd0);
    chk("t1_busy0",  {31'd0, busy},      32'd0);
    chk("t1_error",  {31'd0, error},     32'd0);
    chk("t1_wcount", 32'(word_count),    32'd2);
    chk("t1_writes", 32'(wr_cnt - base), 32'd2);
    chk("t1_mem0",   wr_mem[0],          32'h00000013);
    chk("t1_mem1",   wr_mem[1],          32'h00100093);

    // Test 2: bad magic
    base = wr_cnt;
    pulse_start();
    chk("t2_cpurst_on_start", {31'd0, cpu_reset}, 32'd1);
    chk("t2_wcount_clr",      32'(word_count),    32'd0);
    send_byte(8'h5A, 0);
    chk("t2_error",  {31'd0, error},     32'd1);
    chk("t2_done",   {31'd0, done},      32'd0);
    chk("t2_cpurst", {31'd0, cpu_reset}, 32'd1);
    chk("t2_ready",  {31'd0, rx_ready},  32'd0);
    chk("t2_writes", 32'(wr_cnt - base), 32'd0);

    // Test 3: empty image, good then bad checksum
    base = wr_cnt;
    pulse_start();
    build_frame(0, 16'd0, 8'h00);
    send_range(0, frame.size(), 0);
    chk("t3_done",   {31'd0, done},      32'd1);
    chk("t3_cpurst", {31'd0, cpu_reset}, 32'd0);
    chk("t3_writes", 32'(wr_cnt - base), 32'd0);
    pulse_start();
    chk("t3_done_clr", {31'd0, done}, 32'd0);
    build_frame(0, 16'd0, 8'h01);
    send_range(0, frame.size(), 0);
    chk("t3_bad_error", {31'd0, error}, 32'd1);
    chk("t3_bad_done",  {31'd0, done},  32'd0);

    // Test 4a: N = 9 exceeds capacity of 8
    base = wr_cnt;
    pulse_start();
    send_byte(8'hA5, 0); send_byte(8'h09, 0); send_byte(8'h00, 0);
    chk("t4_over_error",  {31'd0, error},     32'd1);
    chk("t4_over_writes", 32'(wr_cnt - base), 32'd0);

    // Test 4b: N = 8 full fill
    for (int i = 0; i < 8; i++) pw[i] = {8'(i) + 8'h10, 8'hA0 ^ 8'(i), 8'(i * 7), 8'h33};
    base = wr_cnt;
    pulse_start();
    build_frame(8, 16'd8, 8'h00);
    send_range(0, frame.size(), 0);
    chk("t4_full_done",   {31'd0, done},      32'd1);
    chk("t4_full_wcount", 32'(word_count),    32'd8);
    chk("t4_full_writes", 32'(wr_cnt - base), 32'd8);
    chk("t4_last_addr",   32'(last_addr),     32'd7);
    for (int i = 0; i < 8; i++) chk($sformatf("t4_mem%0d", i), wr_mem[i], pw[i]);

    // Test 5: random valid gaps, plus a start pulse mid-load that must be ignored
    pw[0] = 32'hDEADBEEF; pw[1] = 32'h01234567; pw[2] = 32'hCAFEF00D;
    base = wr_cnt;
    pulse_start();
    build_frame(3, 16'd3, 8'h00);
    send_range(0, 5, 3);
    pulse_start();
    chk("t5_start_ignored", {31'd0, busy}, 32'd1);
    send_range(5, frame.size(), 3);
    chk("t5_done",   {31'd0, done},      32'd1);
    chk("t5_wcount", 32'(word_count),    32'd3);
    chk("t5_writes", 32'(wr_cnt - base), 32'd3);
    chk("t5_mem0",   wr_mem[0],          32'hDEADBEEF);
    chk("t5_mem1",   wr_mem[1],          32'h01234567);
    chk("t5_mem2",   wr_mem[2],          32'hCAFEF00D);

    // Test 6: reset after 5 payload bytes, then a clean reload
    pw[0] = 32'h11223344; pw[1] = 32'h55667788;
    pulse_start();
    build_frame(2, 16'd2, 8'h00);
    send_range(0, 8, 0);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("t6_ready",  {31'd0, rx_ready},  32'd0);
    chk("t6_cpurst", {31'd0, cpu_reset}, 32'd1);
    chk("t6_busy",   {31'd0, busy},      32'd0);
    chk("t6_wcount", 32'(word_count),    32'd0);
    base = wr_cnt;
    pulse_start();
    send_range(0, frame.size(), 1);
    chk("t6_done",   {31'd0, done},      32'd1);
    chk("t6_cpurst_rel", {31'd0, cpu_reset}, 32'd0);
    chk("t6_writes", 32'(wr_cnt - base), 32'd2);
    chk("t6_mem0",   wr_mem[0],          32'h11223344);
    chk("t6_mem1",   wr_mem[1],          32'h55667788);

    tick(); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
